// File: rtl/ysyx_22041752_booth_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_booth_mul_pkg
//  Description : Shared encodings for the radix-4 Booth multiplier: the
//                multiply-op selector values and the control FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041752_booth_mul_pkg;

    // Multiply-op selector as presented on mul_op.
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;  // low half, sign irrelevant
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;  // signed x signed, high half
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;  // signed x unsigned, high half
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;  // unsigned x unsigned, high half

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } booth_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22041752_booth_sel.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_booth_sel
//  Description : Radix-4 Booth partial-product selector. Decodes one
//                multiplier triplet into 0, +M, +2M, -M or -2M. Negative
//                selections are returned one's-complemented with neg_o set,
//                so the accumulator adder supplies the +1 as a carry-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_booth_sel #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      triplet_i,
    input  logic [XLEN+1:0] m_i,
    output logic [XLEN+3:0] pp_o,
    output logic            neg_o
);

    logic [XLEN+3:0] w_m1;
    logic [XLEN+3:0] w_m2;
    logic [XLEN+3:0] w_mag;
    logic            w_neg;

    // M and 2M sign-extended to the accumulator width.
    assign w_m1 = {{2{m_i[XLEN+1]}}, m_i};
    assign w_m2 = {m_i[XLEN+1], m_i, 1'b0};

    // Booth recoding of {q[i+1], q[i], q[i-1]}.
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (triplet_i)
            3'b001, 3'b010: w_mag = w_m1;
            3'b011:         w_mag = w_m2;
            3'b100: begin
                w_mag = w_m2;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = w_m1;
                w_neg = 1'b1;
            end
            default: begin
                w_mag = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    assign pp_o  = w_neg ? ~w_mag : w_mag;
    assign neg_o = w_neg;

endmodule
`default_nettype wire

// File: rtl/ysyx_22041752_booth_mul.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041752_booth_mul
//  Description : Iterative radix-4 Booth multiplier for the EXE stage.
//                Supports MUL/MULH/MULHSU/MULHU and word-mode MULW with
//                valid/ready on both sides, a zero-operand early-out, a
//                registered result held under back-pressure, and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_booth_mul
    import ysyx_22041752_booth_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mul_op,
    input  logic            mul_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int EXT    = XLEN + 2;          // extended operand width
    localparam int ACC    = XLEN + 4;          // signed accumulator width
    localparam int HALF   = XLEN / 2;
    localparam int N_FULL = XLEN / 2 + 1;      // iterations, full width
    localparam int N_WORD = XLEN / 4 + 1;      // iterations, word mode
    localparam int CNT_W  = $clog2(N_FULL);
    // After N_WORD double-shifts the product LSB sits at this multiplier bit.
    localparam int W_LSB  = EXT - 2 * N_WORD;
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(N_FULL - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORD - 1);

    booth_state_e     state_q;
    logic [1:0]       op_q;
    logic             w_q;
    logic [CNT_W-1:0] cnt_q;
    logic [EXT-1:0]   m_q;
    logic [ACC-1:0]   acc_q;
    logic [EXT-1:0]   mp_q;
    logic             prev_q;
    logic [XLEN-1:0]  result_q;
    logic             out_valid_q;

    logic             w_sext1;
    logic             w_sext2;
    logic [EXT-1:0]   w_ext1;
    logic [EXT-1:0]   w_ext2;
    logic             w_zero;
    logic [ACC-1:0]   w_pp;
    logic             w_neg;
    logic [ACC-1:0]   w_sum;
    logic [ACC-1:0]   acc_d;
    logic [EXT-1:0]   mp_d;
    logic             prev_d;
    logic             w_last;
    logic [XLEN-1:0]  result_d;

    // Operand extension: src1 signed unless MULHU, src2 signed only for
    // MUL/MULH; word mode always sign-extends the low half.
    assign w_sext1 = (mul_op != MUL_OP_MULHU);
    assign w_sext2 = (mul_op == MUL_OP_MUL) || (mul_op == MUL_OP_MULH);
    assign w_ext1  = mul_w ? {{(EXT-HALF){src1[HALF-1]}}, src1[HALF-1:0]}
                           : {{2{w_sext1 & src1[XLEN-1]}}, src1};
    assign w_ext2  = mul_w ? {{(EXT-HALF){src2[HALF-1]}}, src2[HALF-1:0]}
                           : {{2{w_sext2 & src2[XLEN-1]}}, src2};
    assign w_zero  = mul_w ? ((src1[HALF-1:0] == '0) || (src2[HALF-1:0] == '0))
                           : ((src1 == '0) || (src2 == '0));

    ysyx_22041752_booth_sel #(
        .XLEN (XLEN)
    ) u_booth_sel (
        .triplet_i ({mp_q[1:0], prev_q}),
        .m_i       (m_q),
        .pp_o      (w_pp),
        .neg_o     (w_neg)
    );

    // One Booth step: accumulate, then shift {acc, multiplier, q[-1]} right
    // by two with the accumulator sign replicated.
    assign w_sum  = acc_q + w_pp + {{(ACC-1){1'b0}}, w_neg};
    assign acc_d  = {{2{w_sum[ACC-1]}}, w_sum[ACC-1:2]};
    assign mp_d   = {w_sum[1:0], mp_q[EXT-1:2]};
    assign prev_d = mp_q[1];
    assign w_last = w_q ? (cnt_q == LAST_WORD) : (cnt_q == LAST_FULL);

    // Slice the finished product {acc_d, mp_d} according to the captured op.
    always_comb begin
        result_d = '0;
        if (w_q) begin
            result_d = {{HALF{mp_d[W_LSB+HALF-1]}}, mp_d[W_LSB +: HALF]};
        end else if (op_q == MUL_OP_MUL) begin
            result_d = mp_d[XLEN-1:0];
        end else begin
            result_d = {acc_d[XLEN-3:0], mp_d[XLEN+1:XLEN]};
        end
    end

    // Control FSM with datapath registers; flush and reset both abort.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            if (reset) begin
                op_q     <= MUL_OP_MUL;
                w_q      <= 1'b0;
                m_q      <= '0;
                acc_q    <= '0;
                mp_q     <= '0;
                prev_q   <= 1'b0;
                result_q <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= mul_op;
                        w_q  <= mul_w;
                        if (w_zero) begin
                            result_q    <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            m_q     <= w_ext1;
                            acc_q   <= '0;
                            mp_q    <= w_ext2;
                            prev_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_d;
                    mp_q   <= mp_d;
                    prev_q <= prev_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (w_last) begin
                        result_q    <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_booth_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22041752_booth_mul
//  Description : Self-checking bench for the radix-4 Booth multiplier:
//                directed corner cases, back-pressure, flush/reset abort and
//                randomized operations against a wide-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041752_booth_mul;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mul_op;
    logic        mul_w;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22041752_booth_mul #(
        .XLEN (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_op    (mul_op),
        .mul_w     (mul_w),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact RISC-V M semantics via 128-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa;
        logic signed [127:0] pb;
        logic signed [127:0] p;
        logic signed [63:0]  pw;
        if (w) begin
            pw = $signed({{32{a[31]}}, a[31:0]}) * $signed({{32{b[31]}}, b[31:0]});
            return {{32{pw[31]}}, pw[31:0]};
        end
        pa = (op == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
        pb = (op == 2'b00 || op == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = pa * pb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic int exp_latency(input logic w, input logic [63:0] a, input logic [63:0] b);
        if (w) return (a[31:0] == 0 || b[31:0] == 0) ? 1 : 18;
        return (a == 0 || b == 0) ? 1 : 34;
    endfunction

    // Called at a falling edge with the unit idle; returns at the falling
    // edge of cycle 1 (first cycle after the accept edge).
    task automatic launch(input string tag, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        mul_op   = op;
        mul_w    = w;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = {$urandom, $urandom};
        src2     = {$urandom, $urandom};
        mul_op   = 2'($urandom);
        mul_w    = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            chk({tag, "_busy"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
        chk({tag, "_done_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_cyc, input int hold);
        int          cyc;
        logic [63:0] held;
        out_ready = (hold == 0);
        launch(tag, op, w, a, b);
        wait_done(tag, cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_res"}, result, exp_res);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_res"}, result, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    // Abort an in-flight MULHU during CALC cycle 10 by flush or reset, then
    // accept a new MULHU at cycle 11 which must finish at cycle 45.
    task automatic abort_test(input string tag, input logic use_reset);
        logic [63:0] a;
        logic [63:0] b;
        a = 64'h8000_0000_0000_0001;
        b = 64'hFFFF_0000_1234_5678;
        out_ready = 1'b1;
        launch(tag, 2'b11, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        for (int c = 1; c < 10; c++) begin
            chk({tag, "_novalid"}, 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        chk({tag, "_novalid10"}, 64'(out_valid), 64'd0);
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk({tag, "_c11_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_c11_valid"}, 64'(out_valid), 64'd0);
        // 34 cycles after the accept at cycle 11 -> out_valid at cycle 45.
        run_op({tag, "_next"}, 2'b11, 1'b0, a, b, model(2'b11, 1'b0, a, b), 34, 0);
    endtask

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        int          sel;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        mul_op    = 2'b00;
        mul_w     = 1'b0;
        src1      = '0;
        src2      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);

        run_op("mul_3xm5", 2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
               64'hFFFF_FFFF_FFFF_FFF1, 34, 0);
        run_op("mulhu_ones", 2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        run_op("mulh_ones", 2'b01, 1'b0, '1, '1, 64'h0, 34, 0);
        run_op("mulhsu_ones", 2'b10, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
        run_op("mul_zero", 2'b00, 1'b0, 64'd0, 64'h1234, 64'd0, 1, 0);
        // Back-to-back: accepted at cycle 2 after the early-out.
        run_op("mul_after_zero", 2'b00, 1'b0, 64'd7, 64'd6, 64'd42, 34, 0);
        run_op("mulw", 2'b00, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002,
               64'hFFFF_FFFF_FFFF_FFFE, 18, 0);
        run_op("mulw_zero", 2'b00, 1'b1, 64'hDEAD_BEEF_0000_0000, 64'h5, 64'd0, 1, 0);
        a = 64'h9234_5678_ABCD_EF01;
        b = 64'h7FFF_0001_8000_FFFF;
        run_op("bp_mulh", 2'b01, 1'b0, a, b, model(2'b01, 1'b0, a, b), 34, 5);

        // flush together with in_valid in IDLE must not accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        src1     = 64'd9;
        src2     = 64'd9;
        mul_op   = 2'b00;
        mul_w    = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_idle_ready", 64'(in_ready), 64'd1);
            chk("flush_idle_valid", 64'(out_valid), 64'd0);
        end

        abort_test("flush", 1'b0);
        abort_test("reset", 1'b1);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            w   = (op == 2'b00) && ($urandom_range(0, 2) == 0);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) a = '0;
            if (sel == 1) b[31:0] = '0;
            if (sel == 2) a = '1;
            if (sel == 3) b = 64'h8000_0000_0000_0000;
            run_op("rnd", op, w, a, b, model(op, w, a, b), exp_latency(w, a, b),
                   $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
